// File: rtl/axi_write_slave_ram_pkg.sv
// AXI write-channel request/response bundles used by the RAM-backed write slave.
package axi_write_slave_ram_pkg;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef struct packed {
        logic                    awvalid;
        logic [AXI_ID_W-1:0]     awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    wvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    bready;
    } axi_mosi_t;

    typedef struct packed {
        logic                awready;
        logic                wready;
        logic                bvalid;
        logic [AXI_ID_W-1:0] bid;
        logic [1:0]          bresp;
        logic                arready;
        logic                rvalid;
    } axi_miso_t;
endpackage

// File: rtl/axi_write_slave_ram.sv
// AXI write-only slave backed by a byte-lane-writable RAM; one burst in flight.
// state | meaning
// IDLE  | AWREADY high, waiting for a write address
// DATA  | WREADY high, consuming beats until WLAST
// RESP  | BVALID high, holding BID/BRESP until BREADY
module axi_write_slave_ram
    import axi_write_slave_ram_pkg::*;
#(
    parameter int ID_W      = AXI_ID_W,
    parameter int ADDR_W    = AXI_ADDR_W,
    parameter int DATA_W    = AXI_DATA_W,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  axi_mosi_t                    s_axi_i,
    output axi_miso_t                    s_axi_o,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              slverr_q, slverr_d;
    logic              decerr_q, decerr_d;

    logic              aw_hs, w_hs, b_hs;
    logic              in_range, wr_en;
    logic [ADDR_W-1:0] addr_incr, wrap_mask, addr_next;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign aw_hs = s_axi_i.awvalid && awready_q;
    assign w_hs  = s_axi_i.wvalid && wready_q;
    assign b_hs  = s_axi_i.bready && bvalid_q;

    assign addr_incr = ADDR_W'(1) << size_q;
    assign wrap_mask = (ADDR_W'({1'b0, len_q} + 9'd1) << size_q) - ADDR_W'(1);

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            2'd1:    addr_next = addr_q + addr_incr;
            2'd2:    addr_next = (addr_q & ~wrap_mask) | ((addr_q + addr_incr) & wrap_mask);
            default: addr_next = addr_q;
        endcase
    end

    // A bad size/burst flags SLVERR at AW time, which also blocks every write of the burst.
    assign in_range = (addr_q >> LSB) < ADDR_W'(MEM_DEPTH);
    assign wr_en    = w_hs && in_range && !slverr_q;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        slverr_d = slverr_q;
        decerr_d = decerr_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    id_d     = s_axi_i.awid;
                    addr_d   = s_axi_i.awaddr;
                    len_d    = s_axi_i.awlen;
                    size_d   = s_axi_i.awsize;
                    burst_d  = s_axi_i.awburst;
                    cnt_d    = 8'd0;
                    decerr_d = 1'b0;
                    slverr_d = (s_axi_i.awburst == 2'd3) || (s_axi_i.awsize > 3'(LSB));
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    addr_d = addr_next;
                    if (!in_range) decerr_d = 1'b1;
                    // Counter parks at AWLEN so overrun beats never wrap it.
                    if (cnt_q != len_q) begin
                        cnt_d = cnt_q + 8'd1;
                        if (s_axi_i.wlast) slverr_d = 1'b1;
                    end else if (!s_axi_i.wlast) begin
                        slverr_d = 1'b1;
                    end
                    if (s_axi_i.wlast) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        awready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_DATA);
        bvalid_d  = (state_d == ST_RESP);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            slverr_q  <= 1'b0;
            decerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            slverr_q  <= slverr_d;
            decerr_q  <= decerr_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi_i.wstrb[i]) mem[addr_q[LSB +: IDX_W]][8*i +: 8] <= s_axi_i.wdata[8*i +: 8];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

    always_comb begin
        s_axi_o         = '0;
        s_axi_o.awready = awready_q;
        s_axi_o.wready  = wready_q;
        s_axi_o.bvalid  = bvalid_q;
        s_axi_o.bid     = id_q;
        s_axi_o.bresp   = decerr_q ? 2'd3 : (slverr_q ? 2'd2 : 2'd0);
        s_axi_o.arready = 1'b0;
        s_axi_o.rvalid  = 1'b0;
    end
endmodule

// File: tb/tb_axi_write_slave_ram.sv
// Directed bench for axi_write_slave_ram: B responses go through an expected-response queue.
module tb_axi_write_slave_ram;
    import axi_write_slave_ram_pkg::*;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    logic        ACLK;
    logic        ARESETn;
    axi_mosi_t   s_i;
    axi_miso_t   s_o;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;
    int          n_pass  = 0;
    int          n_total = 0;
    b_exp_t      sb [$];

    axi_write_slave_ram #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s_axi_i (s_i),
        .s_axi_o (s_o),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_mem(input string tag, input int idx, input logic [31:0] exp);
        dbg_addr = 8'(idx);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt, input bit push,
                           input logic [1:0] resp);
        int n = 0;
        s_i.awvalid = 1'b1;
        s_i.awid    = id;
        s_i.awaddr  = addr;
        s_i.awlen   = len;
        s_i.awsize  = size;
        s_i.awburst = bt;
        if (push) sb.push_back({id, resp});
        while (!s_o.awready && n < 100) begin
            tick();
            n++;
        end
        chk("aw_wait", 32'(n < 100), 32'd1);
        tick();
        s_i.awvalid = 1'b0;
        chk("aw_then_wready", 32'(s_o.wready), 32'd1);
        chk("aw_then_awready", 32'(s_o.awready), 32'd0);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] st, input bit last);
        int n = 0;
        s_i.wvalid = 1'b1;
        s_i.wdata  = d;
        s_i.wstrb  = st;
        s_i.wlast  = last;
        while (!s_o.wready && n < 100) begin
            tick();
            n++;
        end
        chk("w_wait", 32'(n < 100), 32'd1);
        tick();
        s_i.wvalid = 1'b0;
        s_i.wlast  = 1'b0;
    endtask

    task automatic recv_b(input int hold);
        int     n = 0;
        b_exp_t e;
        e = '0;
        while (!s_o.bvalid && n < 100) begin
            tick();
            n++;
        end
        chk("b_wait", 32'(n < 100), 32'd1);
        chk("b_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) e = sb.pop_front();
        chk("bid", 32'(s_o.bid), 32'(e.id));
        chk("bresp", 32'(s_o.bresp), 32'(e.resp));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_bvalid", 32'(s_o.bvalid), 32'd1);
            chk("hold_bid", 32'(s_o.bid), 32'(e.id));
            chk("hold_bresp", 32'(s_o.bresp), 32'(e.resp));
            chk("hold_awready", 32'(s_o.awready), 32'd0);
        end
        s_i.bready = 1'b1;
        tick();
        s_i.bready = 1'b0;
        chk("b_done_bvalid", 32'(s_o.bvalid), 32'd0);
        chk("b_done_awready", 32'(s_o.awready), 32'd1);
    endtask

    initial begin
        b_exp_t e;
        s_i      = '0;
        dbg_addr = '0;
        ARESETn  = 1'b0;
        repeat (3) tick();
        chk("rst_awready", 32'(s_o.awready), 32'd0);
        chk("rst_wready", 32'(s_o.wready), 32'd0);
        chk("rst_bvalid", 32'(s_o.bvalid), 32'd0);
        chk("rst_bid", 32'(s_o.bid), 32'd0);
        chk("rst_bresp", 32'(s_o.bresp), 32'd0);
        ARESETn = 1'b1;
        tick();
        chk("post_rst_awready", 32'(s_o.awready), 32'd1);

        // Prime words 0..47 with a recognisable pattern
        send_aw(4'd1, 32'h0, 8'd47, 3'd2, 2'd1, 1'b1, 2'd0);
        for (int i = 0; i < 48; i++) send_w(32'hEE00_0000 + 32'(i), 4'hF, i == 47);
        recv_b(0);
        chk_mem("prime_w0", 0, 32'hEE00_0000);
        chk_mem("prime_w47", 47, 32'hEE00_002F);

        // Two-beat INCR
        send_aw(4'd3, 32'h10, 8'd1, 3'd2, 2'd1, 1'b1, 2'd0);
        send_w(32'h1111_1111, 4'hF, 1'b0);
        send_w(32'h2222_2222, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("incr_w4", 4, 32'h1111_1111);
        chk_mem("incr_w5", 5, 32'h2222_2222);

        // Back-to-back handshakes with every valid/ready held high
        tick();
        chk("tp_pre_awready", 32'(s_o.awready), 32'd1);
        sb.push_back({4'd5, 2'd0});
        s_i.awvalid = 1'b1; s_i.awid = 4'd5; s_i.awaddr = 32'hC0; s_i.awlen = 8'd0;
        s_i.awsize  = 3'd2; s_i.awburst = 2'd1;
        s_i.wvalid  = 1'b1; s_i.wdata = 32'h0BAD_F00D; s_i.wstrb = 4'hF; s_i.wlast = 1'b1;
        s_i.bready  = 1'b1;
        tick();
        s_i.awvalid = 1'b0;
        chk("tp_e1_wready", 32'(s_o.wready), 32'd1);
        chk("tp_e1_awready", 32'(s_o.awready), 32'd0);
        chk("tp_e1_bvalid", 32'(s_o.bvalid), 32'd0);
        tick();
        s_i.wvalid = 1'b0;
        s_i.wlast  = 1'b0;
        e = sb.pop_front();
        chk("tp_e2_bvalid", 32'(s_o.bvalid), 32'd1);
        chk("tp_e2_wready", 32'(s_o.wready), 32'd0);
        chk("tp_e2_bid", 32'(s_o.bid), 32'(e.id));
        chk("tp_e2_bresp", 32'(s_o.bresp), 32'(e.resp));
        tick();
        s_i.bready = 1'b0;
        chk("tp_e3_awready", 32'(s_o.awready), 32'd1);
        chk("tp_e3_bvalid", 32'(s_o.bvalid), 32'd0);
        chk_mem("tp_w48", 48, 32'h0BAD_F00D);

        // FIXED burst hits the same word every beat
        send_aw(4'd2, 32'h20, 8'd2, 3'd2, 2'd0, 1'b1, 2'd0);
        send_w(32'hA, 4'hF, 1'b0);
        send_w(32'hB, 4'hF, 1'b0);
        send_w(32'hC, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("fixed_w8", 8, 32'h0000_000C);
        chk_mem("fixed_w9", 9, 32'hEE00_0009);

        // Byte strobes: lanes 0 and 2 only
        send_aw(4'd4, 32'h30, 8'd1, 3'd2, 2'd0, 1'b1, 2'd0);
        send_w(32'hFFFF_FFFF, 4'hF, 1'b0);
        send_w(32'hAABB_CCDD, 4'h5, 1'b1);
        recv_b(0);
        chk_mem("strb_w12", 12, 32'hFFBB_FFDD);

        // WRAP in a 16-byte window starting mid-window
        send_aw(4'd6, 32'h68, 8'd3, 3'd2, 2'd2, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) send_w(32'h5700_0000 + 32'(i), 4'hF, i == 3);
        recv_b(0);
        chk_mem("wrap_w26", 26, 32'h5700_0000);
        chk_mem("wrap_w27", 27, 32'h5700_0001);
        chk_mem("wrap_w24", 24, 32'h5700_0002);
        chk_mem("wrap_w25", 25, 32'h5700_0003);

        // Out of range: address aliases word 0 if the range check is missing
        send_aw(4'd7, 32'h400, 8'd0, 3'd2, 2'd1, 1'b1, 2'd3);
        send_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("decerr_w0", 0, 32'hEE00_0000);

        // Early WLAST on beat 0 of a 4-beat burst
        send_aw(4'd2, 32'h40, 8'd3, 3'd2, 2'd1, 1'b1, 2'd2);
        send_w(32'h5A5A_5A5A, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("early_w16", 16, 32'h5A5A_5A5A);
        chk_mem("early_w17", 17, 32'hEE00_0011);

        // Missing WLAST: third beat of a 2-beat burst is not written
        send_aw(4'd4, 32'h50, 8'd1, 3'd2, 2'd1, 1'b1, 2'd2);
        send_w(32'hD000_0000, 4'hF, 1'b0);
        send_w(32'hD000_0001, 4'hF, 1'b0);
        send_w(32'hD000_0002, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("over_w20", 20, 32'hD000_0000);
        chk_mem("over_w21", 21, 32'hD000_0001);
        chk_mem("over_w22", 22, 32'hEE00_0016);

        // Oversized beat, reserved burst, and DECERR-over-SLVERR priority
        send_aw(4'd8, 32'h70, 8'd0, 3'd3, 2'd1, 1'b1, 2'd2);
        send_w(32'h1234_5678, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("size_w28", 28, 32'hEE00_001C);
        send_aw(4'd9, 32'h74, 8'd0, 3'd2, 2'd3, 1'b1, 2'd2);
        send_w(32'h1234_5678, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("rsvd_w29", 29, 32'hEE00_001D);
        send_aw(4'd10, 32'h400, 8'd0, 3'd2, 2'd3, 1'b1, 2'd3);
        send_w(32'h1234_5678, 4'hF, 1'b1);
        recv_b(0);

        // BREADY withheld while a second AW waits
        send_aw(4'd6, 32'h90, 8'd0, 3'd2, 2'd1, 1'b1, 2'd0);
        send_w(32'h3636_3636, 4'hF, 1'b1);
        s_i.awvalid = 1'b1; s_i.awid = 4'd7; s_i.awaddr = 32'h94; s_i.awlen = 8'd0;
        s_i.awsize  = 3'd2; s_i.awburst = 2'd1;
        recv_b(5);
        send_aw(4'd7, 32'h94, 8'd0, 3'd2, 2'd1, 1'b1, 2'd0);
        send_w(32'h3737_3737, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("hold_w36", 36, 32'h3636_3636);
        chk_mem("hold_w37", 37, 32'h3737_3737);

        // Reset after beat 1 of a 4-beat burst abandons it
        send_aw(4'd8, 32'hA0, 8'd3, 3'd2, 2'd1, 1'b0, 2'd0);
        send_w(32'h4040_4040, 4'hF, 1'b0);
        send_w(32'h4141_4141, 4'hF, 1'b0);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_awready", 32'(s_o.awready), 32'd0);
        chk("mid_rst_wready", 32'(s_o.wready), 32'd0);
        chk("mid_rst_bvalid", 32'(s_o.bvalid), 32'd0);
        chk("mid_rst_bid", 32'(s_o.bid), 32'd0);
        chk("mid_rst_bresp", 32'(s_o.bresp), 32'd0);
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
        chk("mid_rel_awready", 32'(s_o.awready), 32'd1);
        tick();
        chk("mid_rel_no_b", 32'(s_o.bvalid), 32'd0);
        chk_mem("mid_w40", 40, 32'h4040_4040);
        chk_mem("mid_w41", 41, 32'h4141_4141);
        chk_mem("mid_w42", 42, 32'hEE00_002A);
        send_aw(4'd9, 32'hA8, 8'd0, 3'd2, 2'd1, 1'b1, 2'd0);
        send_w(32'h7777_7777, 4'hF, 1'b1);
        recv_b(0);
        chk_mem("post_rst_w42", 42, 32'h7777_7777);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
